// File: rtl/filter_pkg.sv
// Shared types and constants for the input filter channel.
// Edge-select codes, FSM encoding and the window counter width.
package filter_pkg;

    localparam int WIN_W = 4;

    localparam logic [1:0] FT_NONE = 2'b00;
    localparam logic [1:0] FT_RISE = 2'b01;
    localparam logic [1:0] FT_FALL = 2'b10;
    localparam logic [1:0] FT_BOTH = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_e;

    // True when an update to new_lvl is an edge selected by ftype.
    function automatic logic edge_match(input logic new_lvl,
                                        input logic [1:0] ftype);
        logic rise_ok;
        logic fall_ok;
        rise_ok = (ftype == FT_RISE) || (ftype == FT_BOTH);
        fall_ok = (ftype == FT_FALL) || (ftype == FT_BOTH);
        return new_lvl ? rise_ok : fall_ok;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Resettable multi-flop synchronizer for one asynchronous bit.
// Pure shift chain: nothing sits between the flops.
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_filter_channel.sv
// Single-channel deglitch filter with qualified-edge interrupt pulse.
// A new level is accepted only after W+1 consecutive differing samples.
module input_filter_channel
    import filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             data_i,
    input  logic [1:0]       filter_type_i,
    input  logic [WIN_W-1:0] window_size_i,
    input  logic             int_en_i,
    output logic             data_o,
    output logic             int_pulse_o
);

    logic             s;
    logic             upd;
    state_e           state_q;
    state_e           state_d;
    logic [WIN_W-1:0] cnt_q;
    logic [WIN_W-1:0] cnt_d;
    logic             data_q;
    logic             data_d;
    logic             pulse_q;
    logic             pulse_d;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (data_i),
        .q_o    (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pulse_d = 1'b0;
        upd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s == data_q) begin
                    cnt_d = '0;
                end else if (window_size_i == '0) begin
                    upd = 1'b1;
                end else begin
                    state_d = QUAL;
                    cnt_d   = 4'd1;
                end
            end
            QUAL: begin
                if (s == data_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                // >= lets a shrunken window finish on the next sample
                end else if (cnt_q >= window_size_i) begin
                    upd     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
        if (upd) begin
            data_d  = s;
            pulse_d = int_en_i && edge_match(s, filter_type_i);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
        end
    end

    assign data_o      = data_q;
    assign int_pulse_o = pulse_q;

endmodule

// File: tb/tb_input_filter_channel.sv
// Directed-vector bench for input_filter_channel (default parameters).
// Expected values are hand-derived from the edge-count latency rules.
module tb_input_filter_channel;
    import filter_pkg::*;

    logic       clk;
    logic       rstn;
    logic       data_in;
    logic [1:0] ftype;
    logic [3:0] win;
    logic       int_en;
    logic       data_out;
    logic       pulse;

    int vectors;
    int miscompares;

    input_filter_channel dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .data_i        (data_in),
        .filter_type_i (ftype),
        .window_size_i (win),
        .int_en_i      (int_en),
        .data_o        (data_out),
        .int_pulse_o   (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive val, expect data_out to follow on exactly edge n.
    task automatic run_edge(input logic val, input int n,
                            input logic exp_pulse, input string tag);
        data_in = val;
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_hold"}, {3'b0, data_out}, {3'b0, ~val});
            check({tag, "_nopulse"}, {3'b0, pulse}, 4'h0);
        end
        tick();
        check({tag, "_upd"}, {3'b0, data_out}, {3'b0, val});
        check({tag, "_pulse"}, {3'b0, pulse}, {3'b0, exp_pulse});
        tick();
        check({tag, "_pulse_end"}, {3'b0, pulse}, 4'h0);
        check({tag, "_idle"}, {3'b0, dut.state_q}, {3'b0, IDLE});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        data_in     = 1'b0;
        ftype       = FT_RISE;
        win         = 4'd3;
        int_en      = 1'b1;
        repeat (3) tick();
        check("rst_data", {3'b0, data_out}, 4'h0);
        check("rst_pulse", {3'b0, pulse}, 4'h0);
        check("rst_cnt", dut.cnt_q, 4'h0);
        rstn = 1'b1;
        repeat (3) tick();
        check("idle_data", {3'b0, data_out}, 4'h0);

        // W=3 rising, enabled: update on edge 6 with one pulse
        run_edge(1'b1, 6, 1'b1, "w3_rise");
        // W=3 falling with rising-only select: no pulse
        run_edge(1'b0, 6, 1'b0, "w3_fall");

        // 3-cycle glitch with W=3 is rejected
        data_in = 1'b1;
        repeat (3) tick();
        data_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_data", {3'b0, data_out}, 4'h0);
            check("glitch_pulse", {3'b0, pulse}, 4'h0);
        end
        check("glitch_state", {3'b0, dut.state_q}, {3'b0, IDLE});
        check("glitch_cnt", dut.cnt_q, 4'h0);

        // W=0 both edges: 3-cycle latency, two pulses
        win   = 4'd0;
        ftype = FT_BOTH;
        run_edge(1'b1, 3, 1'b1, "w0_rise");
        repeat (6) tick();
        run_edge(1'b0, 3, 1'b1, "w0_fall");

        // W=2 rising only, then interrupts disabled
        win   = 4'd2;
        ftype = FT_RISE;
        run_edge(1'b1, 5, 1'b1, "w2_rise");
        run_edge(1'b0, 5, 1'b0, "w2_fall_masked");
        int_en = 1'b0;
        ftype  = FT_BOTH;
        run_edge(1'b1, 5, 1'b0, "dis_rise");
        run_edge(1'b0, 5, 1'b0, "dis_fall");

        // Config churn alone never moves data_out or pulses
        int_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ftype = 2'(i);
            win   = 4'(i * 5);
            tick();
            check("cfg_data", {3'b0, data_out}, 4'h0);
            check("cfg_pulse", {3'b0, pulse}, 4'h0);
        end

        // W=7, shrink to 2 at cnt=4: update on the next edge
        ftype   = FT_BOTH;
        win     = 4'd7;
        data_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("shrink_hold", {3'b0, data_out}, 4'h0);
        end
        check("shrink_cnt4", dut.cnt_q, 4'h4);
        win = 4'd2;
        tick();
        check("shrink_upd", {3'b0, data_out}, 4'h1);
        check("shrink_pulse", {3'b0, pulse}, 4'h1);
        tick();
        check("shrink_pulse_end", {3'b0, pulse}, 4'h0);

        // Return low, then abort a W=15 qualification with reset
        run_edge(1'b0, 5, 1'b1, "pre_rst_fall");
        win     = 4'd15;
        data_in = 1'b1;
        repeat (10) tick();
        check("mid_qual_cnt", dut.cnt_q, 4'h8);
        check("mid_qual_state", {3'b0, dut.state_q}, {3'b0, QUAL});
        rstn = 1'b0;
        #1;
        check("arst_data", {3'b0, data_out}, 4'h0);
        check("arst_pulse", {3'b0, pulse}, 4'h0);
        check("arst_cnt", dut.cnt_q, 4'h0);
        check("arst_state", {3'b0, dut.state_q}, {3'b0, IDLE});
        tick();
        rstn = 1'b1;
        run_edge(1'b1, 18, 1'b1, "post_rst_rise");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_filter_channel.md
Name: input_filter_channel

Overview:
Single-channel digital deglitch filter and edge detector. One instance per channel, replicated N times in the filter array. It consumes one channel's configuration fields from the register block: filter_type, window_size and int_en. It produces the filtered level and a one-cycle interrupt pulse, which feeds bit i of the register block's in_int_i status input.

Parameters:
SYNC_STAGES, 2, number of flops in the input synchronizer chain (min 2)
RST_VAL, 1'b0, reset value of the synchronizer flops and data_o

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
data_i  input  1  raw asynchronous channel input
filter_type_i  input  2  interrupt edge select: 00 none, 01 rising, 10 falling, 11 both
window_size_i  input  4  stability window W; W+1 consecutive differing samples are required
int_en_i  input  1  interrupt enable
data_o  output  1  filtered, deglitched level (registered)
int_pulse_o  output  1  one-cycle interrupt pulse on a qualified edge (registered)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i / rstn_i).
- Reset values: all sync flops = RST_VAL; data_o = RST_VAL; int_pulse_o = 0; cnt = 0; state = IDLE.
- Synchronizer: data_i passes through SYNC_STAGES flops; s denotes the last flop's output. No logic is permitted between the synchronizer flops.
- FSM states: IDLE, QUAL. cnt is 4 bits.
- IDLE, s == data_o: stay in IDLE, cnt = 0.
- IDLE, s != data_o, W == 0: data_o <= s this edge, stay in IDLE.
- IDLE, s != data_o, W > 0: go to QUAL, cnt <= 1.
- QUAL, s == data_o: glitch rejected; go to IDLE, cnt <= 0, data_o unchanged, no pulse.
- QUAL, s != data_o, cnt >= W: data_o <= s; go to IDLE; cnt <= 0.
- QUAL, s != data_o, cnt < W: cnt <= cnt + 1.
- The comparison is >= (not ==) so a live reduction of window_size_i during QUAL completes on the next differing sample.
- cnt never exceeds 15, so no wrap can occur.
- Latency: data_i stable before clock edge 1 -> data_o changes on edge SYNC_STAGES+1+W (W+3 with defaults).
- A pulse of k cycles on data_i, with k <= W, never reaches data_o.
- Interrupt: int_pulse_o is asserted for exactly one cycle, registered on the same edge that data_o updates, iff int_en_i = 1 and the edge matches filter_type_i:
  - rising (0->1) needs type 01 or 11;
  - falling (1->0) needs type 10 or 11.
  - filter_type_i and int_en_i are sampled on that update edge.
  - Otherwise int_pulse_o = 0.
- Back-to-back edges: the earliest next update is W+1 cycles later, so pulses never merge.
- Config changes never alter data_o directly and never generate a pulse by themselves.
- Reset asserted mid-QUAL aborts qualification immediately: all reset values apply and no pulse is produced.

Decomposition:
- Shared package filter_pkg:
  - filter-type constants FT_NONE=2'b00, FT_RISE=2'b01, FT_FALL=2'b10, FT_BOTH=2'b11;
  - FSM state encoding (IDLE, QUAL);
  - WIN_W = 4.
- One natural sub-module: bit_sync (SYNC_STAGES-deep reset-able synchronizer), reusable by other asynchronous inputs.

Test Plan:
- W=3, type=01, int_en=1, data_i 0->1 held: data_o rises on edge 6, int_pulse_o=1 for that single cycle only.
- W=3, data_i high for 3 cycles then low: data_o stays 0, int_pulse_o never asserts, FSM returns to IDLE.
- W=0, type=11: data_i 0->1 then 1->0 after 10 cycles: data_o follows each edge with 3-cycle latency, two pulses.
- W=2, type=01 (rising only): data_o 1->0 transition gives no pulse; int_en=0 with type=11 gives no pulse on any edge.
- W=7, data_i 0->1; when cnt=4, window_size_i becomes 2: data_o updates on the next edge, one pulse.
- Mid-QUAL (W=15, cnt=8), assert rstn_i=0 asynchronously: data_o=0 and int_pulse_o=0 immediately. After release with data_i=1 held, full W+3 latency restarts.
